// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter with terminal-count pulse and auto-reload
module down_counter_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  // State register: reset dominates every other action on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next state: load beats terminal count, terminal count beats plain decrement.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      s_d      = load_value;
      reload_d = load_value;
      state_d  = (load_value != CNT_ZERO) ? RUN : IDLE;
    end else if (state_q == RUN && enable) begin
      if (s_q == CNT_ONE) begin
        done_d = 1'b1;
        if (auto_reload) begin
          s_d = reload_q;
        end else begin
          s_d     = CNT_ZERO;
          state_d = IDLE;
        end
      end else begin
        s_d = s_q - CNT_ONE;
      end
    end
  end

  // Outputs: count, busy and done come straight from flops; zero is decoded.
  always_comb begin
    S    = s_q;
    busy = (state_q == RUN);
    done = done_q;
    zero = (s_q == CNT_ZERO);
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - self-checking bench for down_counter_timer
module tb_down_counter_timer;

  localparam int WIDTH = 3;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] S;
  logic             busy;
  logic             done;
  logic             zero;

  int n_checks;
  int n_fail;

  // Reference: remaining count, reload value, running flag, pulse flag.
  int m_s;
  int m_rel;
  int m_run;
  int m_done;
  int m_valid;
  int done_seen;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .auto_reload(auto_reload),
    .S          (S),
    .busy       (busy),
    .done       (done),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model advanced on every rising edge from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_s = 0; m_rel = 0; m_run = 0; m_done = 0; m_valid = 1;
    end else if (load) begin
      m_s = int'(load_value); m_rel = int'(load_value);
      m_run = (load_value != 0) ? 1 : 0; m_done = 0;
    end else if (m_run != 0 && enable) begin
      if (m_s == 1) begin
        m_done = 1;
        if (auto_reload) m_s = m_rel;
        else begin m_s = 0; m_run = 0; end
      end else begin
        m_s = m_s - 1; m_done = 0;
      end
    end else begin
      m_done = 0;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid != 0) begin
      check("model_S", int'(S), m_s);
      check("model_busy", int'(busy), m_run);
      check("model_done", int'(done), m_done);
      check("model_zero", int'(zero), (m_s == 0) ? 1 : 0);
    end
  end

  task automatic cyc(input logic rst, input logic ld, input int lv, input logic en, input logic ar);
    @(negedge clk);
    reset = rst; load = ld; load_value = WIDTH'(lv); enable = en; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int s, input int b, input int d);
    check({name, "_S"}, int'(S), s);
    check({name, "_busy"}, int'(busy), b);
    check({name, "_done"}, int'(done), d);
    check({name, "_zero"}, int'(zero), (s == 0) ? 1 : 0);
  endtask

  initial begin
    int seq2[6] = '{5, 4, 3, 2, 1, 0};
    int en3[5]  = '{1, 0, 0, 1, 1};
    int s3[5]   = '{2, 2, 2, 1, 0};
    n_checks = 0; n_fail = 0; m_valid = 0;
    m_s = 0; m_rel = 0; m_run = 0; m_done = 0;
    reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;

    // 1. Reset then idle with enable high.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      expect_out("idle", 0, 0, 0);
    end

    // 2. One-shot count from 5.
    cyc(0, 1, 5, 0, 0);
    expect_out("oneshot_load", 5, 1, 0);
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0);
      expect_out("oneshot", seq2[i], (seq2[i] != 0) ? 1 : 0, (seq2[i] == 0) ? 1 : 0);
    end
    cyc(0, 0, 0, 1, 0);
    expect_out("oneshot_after", 0, 0, 0);

    // 3. Gated enable.
    cyc(0, 1, 3, 0, 0);
    expect_out("gated_load", 3, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, logic'(en3[i]), 0);
      expect_out("gated", s3[i], (s3[i] != 0) ? 1 : 0, (i == 4) ? 1 : 0);
    end

    // 4. Auto-reload from 7: pulse every 7 enabled cycles.
    cyc(0, 1, 7, 0, 1);
    done_seen = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 0, 1, 1);
      expect_out("autoreload", 7 - (k % 7), 1, ((k % 7) == 0) ? 1 : 0);
      done_seen += int'(done);
    end
    check("autoreload_pulses", done_seen, 2);

    // Auto-reload with 1: done every enabled cycle.
    cyc(0, 1, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 1);
      expect_out("reload_one", 1, 1, 1);
    end

    // 5. Collisions: load at terminal count, then load of zero.
    cyc(0, 1, 2, 0, 0);
    cyc(0, 0, 0, 1, 0);
    expect_out("coll_pre", 1, 1, 0);
    cyc(0, 1, 4, 1, 0);
    expect_out("coll_load", 4, 1, 0);
    cyc(0, 1, 0, 1, 0);
    expect_out("coll_zero", 0, 0, 0);

    // 6. Reset mid-count, together with a load.
    cyc(0, 1, 6, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    expect_out("midrst_pre", 3, 1, 0);
    cyc(1, 1, 5, 1, 0);
    expect_out("midrst", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      expect_out("midrst_after", 0, 0, 0);
    end

    // Random phase, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
          int'($urandom_range(0, 7)),
          ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter / countdown timer: the decrementing counterpart of the team's 3-bit up counter.
- Preloaded with a start value, counts toward zero on enabled clock edges, and signals terminal count with a one-cycle done pulse.
- Optional auto-reload for periodic timing.
- Used as a timeout/interval source alongside the up counter in the same datapath.

Parameters:
- WIDTH, 3, counter width in bits; the start value range is 0 to 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  when high, captures load_value on the next rising edge.
- load_value  input  WIDTH  start/reload count.
- enable  input  1  count-enable; the counter decrements only when high and in RUN.
- auto_reload  input  1  sampled at terminal count: 1 = restart from the reload value, 0 = stop.
- S  output  WIDTH  current count (registered).
- busy  output  1  high while in RUN (registered).
- done  output  1  one-cycle pulse at terminal count (registered).
- zero  output  1  combinational, high when S == 0.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - S = 0, internal reload register = 0, state = IDLE.
  - busy = 0, done = 0; zero = 1 as a consequence.
  - Reset asserted mid-count aborts the count on that edge with no done pulse.
- States: IDLE and RUN. busy = (state == RUN).
- Priority at each rising edge: reset > load > terminal count / decrement > hold.
- Load, valid in either state:
  - S <= load_value and reload register <= load_value.
  - If load_value != 0, state <= RUN; if load_value == 0, state <= IDLE.
  - done <= 0 on a load edge, even if a terminal count coincides. Load wins and no pulse is issued.
- RUN, enable = 0: S holds, state holds, done <= 0.
- RUN, enable = 1, S > 1: S <= S - 1, done <= 0.
- RUN, enable = 1, S == 1 (terminal count):
  - done <= 1 for exactly one cycle.
  - If auto_reload = 1: S <= reload register and state stays RUN. The period is therefore exactly load_value enabled cycles.
  - If auto_reload = 0: S <= 0 and state <= IDLE.
- IDLE without load: S holds and enable is ignored; done <= 0.
- Wrap-around: S never decrements below 0. S == 0 in RUN is unreachable.
- Latency:
  - Load to S valid: 1 cycle.
  - First decrement: the first enabled edge after the load edge.
  - done asserts in the same cycle that S shows 0 (or shows the reloaded value).
- Width rule: S is unsigned WIDTH bits. The reload register holds WIDTH bits. There is no carry or borrow output.
- done is never asserted for two consecutive cycles, except in auto-reload mode with load_value == 1 and enable held high. In that case done is asserted every cycle.

Test Plan (WIDTH = 3):
1. Reset then idle: assert reset for 2 cycles, release, hold load = 0 and enable = 1 for 5 cycles -> S = 0, zero = 1, busy = 0, done = 0 throughout.
2. One-shot count: load_value = 5, pulse load, then enable = 1 and auto_reload = 0 -> S sequence 5,4,3,2,1,0. done is high only in the cycle S = 0. busy drops in that same cycle. S stays 0 afterwards.
3. Gated enable: load 3, toggle enable 1,0,0,1,1 -> S sequence 3,2,2,2,1,0. done pulses once, at S = 0.
4. Auto-reload: load 7, auto_reload = 1, enable held high for 16 cycles -> S cycles 7,6,...,1,7,6,... with done pulses exactly 7 cycles apart. busy stays 1.
5. Collisions:
   - At S = 1 with enable = 1, assert load with load_value = 4 -> S = 4, done = 0, busy = 1.
   - Load load_value = 0 -> S = 0, IDLE, no done pulse.
6. Reset mid-operation: load 6, count to S = 3, then assert reset together with load = 1 and load_value = 5 -> S = 0, IDLE, done = 0. Afterwards enable has no effect.
